// File: rtl/rca_div_seq_pkg.sv
// Shared definitions for the sequential restoring divider.
// Contents: default operand width, FSM state encoding, and a helper
// that sizes the iteration counter.
package rca_div_seq_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Iteration counter width for a given operand width (WIDTH >= 2).
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/rca_fa.sv
// 1-bit full-adder cell used by the ripple-carry arithmetic blocks.
// Ports: a, b, c_in -> sum, c_out.
module rca_fa (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/rca_sub_w.sv
// Parameterized ripple-borrow subtractor: diff = a + ~b + c_in.
// With c_in = 1 this is a - b; c_out = 1 means no borrow (a >= b).
// Purely combinational.
// Ports: a, b (WIDTH), c_in -> diff (WIDTH), c_out.
module rca_sub_w #(
  parameter int WIDTH = 5
) (
  output logic [WIDTH-1:0] diff,
  output logic             c_out,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in
);

  logic [WIDTH-1:0] b_n_s;
  logic [WIDTH:0]   carry_s;

  assign b_n_s      = ~b;
  assign carry_s[0] = c_in;
  assign c_out      = carry_s[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    rca_fa u_fa (
      .a     (a[i]),
      .b     (b_n_s[i]),
      .c_in  (carry_s[i]),
      .sum   (diff[i]),
      .c_out (carry_s[i+1])
    );
  end

endmodule

// File: rtl/rca_div_seq.sv
// Multi-cycle unsigned restoring divider. One quotient bit per CALC
// cycle using a shared ripple-borrow subtractor; results presented with
// a one-cycle done pulse.
// Ports: clk, rst_n (async, active low), start, dividend, divisor ->
//        busy, done, quotient, remainder, div_by_zero.
module rca_div_seq
  import rca_div_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] d_r;
  logic             dz_r;

  logic [WIDTH:0]   r_shift_s;
  logic [WIDTH:0]   sub_diff_s;
  logic             sub_cout_s;
  logic             accept_s;
  logic             div_zero_s;
  logic             unused_r_msb_s;

  // Partial remainder shifted left with the next dividend bit.
  assign r_shift_s  = {r_r[WIDTH-1:0], q_r[WIDTH-1]};
  // start is only honoured when not busy, i.e. in IDLE or FIN.
  assign accept_s   = start && ((state_r == IDLE) || (state_r == FIN));
  assign div_zero_s = (divisor == {WIDTH{1'b0}});
  // The remainder MSB is always zero after a step since R < D.
  assign unused_r_msb_s = r_r[WIDTH];

  rca_sub_w #(
    .WIDTH (WIDTH + 1)
  ) u_sub (
    .diff  (sub_diff_s),
    .c_out (sub_cout_s),
    .a     (r_shift_s),
    .b     ({1'b0, d_r}),
    .c_in  (1'b1)
  );

  // Divider FSM: iteration control, datapath registers and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      q_r         <= {WIDTH{1'b0}};
      r_r         <= {(WIDTH+1){1'b0}};
      d_r         <= {WIDTH{1'b0}};
      dz_r        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= {WIDTH{1'b0}};
      remainder   <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        CALC: begin
          // Carry-out high: no borrow, keep the difference.
          if (sub_cout_s) begin
            r_r <= sub_diff_s;
            q_r <= {q_r[WIDTH-2:0], 1'b1};
          end else begin
            r_r <= r_shift_s;
            q_r <= {q_r[WIDTH-2:0], 1'b0};
          end
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == LAST_CNT) begin
            state_r <= FIN;
            busy    <= 1'b0;
          end else begin
            state_r <= CALC;
          end
        end
        FIN: begin
          done        <= 1'b1;
          quotient    <= q_r;
          remainder   <= r_r[WIDTH-1:0];
          div_by_zero <= dz_r;
          state_r     <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase

      // Operand load; overrides the next-state chosen above.
      if (accept_s) begin
        cnt_r <= {CW{1'b0}};
        d_r   <= divisor;
        dz_r  <= div_zero_s;
        // Back-to-back from FIN must not clobber the flag being presented.
        if (state_r == IDLE) begin
          div_by_zero <= 1'b0;
        end else begin
          div_by_zero <= dz_r;
        end
        if (div_zero_s) begin
          q_r     <= {WIDTH{1'b1}};
          r_r     <= {1'b0, dividend};
          state_r <= FIN;
          busy    <= 1'b0;
        end else begin
          q_r     <= dividend;
          r_r     <= {(WIDTH+1){1'b0}};
          state_r <= CALC;
          busy    <= 1'b1;
        end
      end else begin
        dz_r <= dz_r;
      end
    end
  end

endmodule

// File: tb/tb_rca_div_seq.sv
// Scoreboard bench for rca_div_seq (WIDTH = 4).
module tb_rca_div_seq;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  rca_div_seq #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: compare every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
      end
    end
  end

  // Present operands for one cycle; returns #1 after the accepting edge.
  task automatic issue(input int a, input int b, input bit push,
                       input int eq, input int er, input bit edz);
    exp_t e;
    @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = WIDTH'(a);
    divisor  = WIDTH'(b);
    if (push) begin
      e.q  = WIDTH'(eq);
      e.r  = WIDTH'(er);
      e.dz = edz;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count busy cycles and find the cycle of done, bounded.
  task automatic wait_done(input int skip, input int exp_lat, input int exp_busy, input string name);
    int lat;
    int bc;
    lat = -1;
    bc  = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k >= skip) begin
        if (busy) bc++;
        if (done) begin
          lat = k;
          break;
        end
      end
    end
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;

    // Basic divisions: done 5 cycles after accept, busy 4 cycles.
    issue(13, 3, 1'b1, 4, 1, 1'b0);
    wait_done(0, 5, 4, "d13_3");
    issue(15, 1, 1'b1, 15, 0, 1'b0);
    wait_done(0, 5, 4, "d15_1");
    issue(7, 9, 1'b1, 0, 7, 1'b0);
    wait_done(0, 5, 4, "d7_9");

    // Divide by zero: done the cycle after accept, busy never high.
    issue(10, 0, 1'b1, 15, 10, 1'b1);
    wait_done(0, 1, 0, "d10_0");

    // Start during busy is ignored; start in FIN is accepted.
    issue(12, 5, 1'b1, 2, 2, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; dividend = 4'd9; divisor = 4'd2;
    @(posedge clk); #1;
    start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("fin_busy", 32'(busy), 32'd0);
    start = 1'b1; dividend = 4'd9; divisor = 4'd2;
    begin
      exp_t e;
      e.q = 4'd4; e.r = 4'd1; e.dz = 1'b0;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done(1, 5, 3, "d9_2_b2b");

    // Reset during the second CALC cycle aborts with no done.
    issue(14, 3, 1'b0, 0, 0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_dz", 32'(div_by_zero), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(14, 3, 1'b1, 4, 2, 1'b0);
    wait_done(0, 5, 4, "d14_3");

    // Exhaustive sweep against a reference model.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          issue(a, b, 1'b1, 15, a, 1'b1);
          wait_done(0, 1, 0, "sweep_dz");
        end else begin
          issue(a, b, 1'b1, a / b, a % b, 1'b0);
          wait_done(0, 5, 4, "sweep");
        end
      end
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
